// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit paths: frame geometry,
// clocking constants and the receiver state encoding.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int CLK_HZ     = 50_000_000;
    localparam int BAUD       = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: line and tick inputs plus the byte/status outputs.
// The master drives the line and tick; the receiver is the slave.
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
) ();

    logic                 RX_TICK;
    logic                 RX;
    logic [DATA_BITS-1:0] DATA;
    logic                 DATA_VALID;
    logic                 FRAME_ERR;
    logic                 BUSY;

    modport master (
        output RX_TICK,
        output RX,
        input  DATA,
        input  DATA_VALID,
        input  FRAME_ERR,
        input  BUSY
    );

    modport slave (
        input  RX_TICK,
        input  RX,
        output DATA,
        output DATA_VALID,
        output FRAME_ERR,
        output BUSY
    );

endinterface

// File: rtl/rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; the reset value is an input
// so idle-high lines such as RX come out of reset in their idle level.
module rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick: recovers LSB-first
// frames, strobes each good byte and flags framing errors and start glitches.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a tick that sees RX low
//   ST_START | counting to mid start bit to reject glitches
//   ST_DATA  | sampling data bits mid-bit, shifting into the MSB
//   ST_STOP  | waiting for mid stop bit to accept or reject the frame
//   ST_BREAK | stop bit was low; wait for the line to go high again
module uart_rx #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic    CLK,
    input  logic    RST,
    uart_rx_if.slave bus
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic rx_s;

    rx_sync #(
        .WIDTH (1)
    ) u_rx_sync (
        .clk     (CLK),
        .rst     (RST),
        .rst_val (1'b1),
        .d       (bus.RX),
        .q       (rx_s)
    );

    rx_state_e            state_d,      state_q;
    logic [CNT_W-1:0]     cnt_d,        cnt_q;
    logic [IDX_W-1:0]     idx_d,        idx_q;
    logic [DATA_BITS-1:0] shift_d,      shift_q;
    logic [DATA_BITS-1:0] data_d,       data_q;
    logic                 data_valid_d, data_valid_q;
    logic                 frame_err_d,  frame_err_q;
    logic                 busy_d,       busy_q;

    logic cnt_end;
    assign cnt_end = (cnt_q == CNT_END);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        // Nothing but the one-cycle pulses may change between ticks.
        if (bus.RX_TICK) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end

                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    cnt_d = cnt_end ? '0 : cnt_q + CNT_ONE;
                    if (cnt_end) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + IDX_ONE;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_STOP;
                            cnt_d   = '0;
                        end
                    end
                end

                ST_STOP: begin
                    cnt_d = cnt_end ? '0 : cnt_q + CNT_ONE;
                    if (cnt_end) begin
                        if (rx_s) begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            frame_err_d  = 1'b1;
                            state_d      = ST_BREAK;
                        end
                    end
                end

                ST_BREAK: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.DATA       = data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.FRAME_ERR  = frame_err_q;
    assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames on a 1-in-28 tick grid, a scoreboard of
// expected frame outcomes, and literal checks that pin the scoreboard.
module tb_uart_rx;

    typedef struct packed {
        logic       is_valid;
        logic [7:0] data;
    } ev_t;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #10 CLK = ~CLK;

    int         n_checks   = 0;
    int         n_pass     = 0;
    int         valid_cnt  = 0;
    int         fe_cnt     = 0;
    int         busy_ticks = 0;
    int         tick_ph    = 0;
    logic       tick_en    = 1'b1;
    logic [7:0] model_data = 8'h00;
    ev_t        exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One tick every 28 CLK, driven away from the sampling edge.
    initial begin
        bus.RX_TICK = 1'b0;
        forever begin
            @(negedge CLK);
            if (tick_en) begin
                tick_ph     = (tick_ph == 27) ? 0 : tick_ph + 1;
                bus.RX_TICK = (tick_ph == 27);
            end else begin
                bus.RX_TICK = 1'b0;
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge CLK);
            while (bus.RX_TICK !== 1'b1) @(posedge CLK);
        end
        @(negedge CLK);
    endtask

    // Line bits: 0 = start, 1..8 = data LSB first, 9 = stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int n_line_bits, input int gap_bit);
        logic [9:0] line;
        ev_t        e;
        line = {stop_v, b, 1'b0};
        if (n_line_bits == 10) begin
            e.is_valid = stop_v;
            e.data     = b;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n_line_bits; i++) begin
            bus.RX = line[i];
            if (i == gap_bit) begin
                wait_ticks(4);
                tick_en = 1'b0;
                repeat (1000) @(negedge CLK);
                check("gap_busy_hold", 32'(bus.BUSY), 32'd1);
                tick_en = 1'b1;
                wait_ticks(12);
            end else begin
                wait_ticks(16);
            end
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected frame outcome,
    // and DATA must always equal the last good byte.
    initial begin
        ev_t ev;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.RX_TICK && bus.BUSY) busy_ticks++;
            if (bus.DATA_VALID || bus.FRAME_ERR) begin
                check("pulse_exclusive", 32'(bus.DATA_VALID & bus.FRAME_ERR), 32'd0);
                if (bus.DATA_VALID) valid_cnt++;
                else fe_cnt++;
                check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", 32'(bus.DATA_VALID), 32'(ev.is_valid));
                    if (ev.is_valid) begin
                        check("frame_data", 32'(bus.DATA), 32'(ev.data));
                        model_data = ev.data;
                    end
                end
            end
            check("data_hold", 32'(bus.DATA), 32'(model_data));
        end
    end

    initial begin
        repeat (95000) @(posedge CLK);
        $display("FAIL watchdog: run exceeded 95000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        RST    = 1'b1;
        bus.RX = 1'b1;
        #1;
        check("rst_data",       32'(bus.DATA),       32'd0);
        check("rst_data_valid", 32'(bus.DATA_VALID), 32'd0);
        check("rst_frame_err",  32'(bus.FRAME_ERR),  32'd0);
        check("rst_busy",       32'(bus.BUSY),       32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        wait_ticks(4);

        busy_ticks = 0;
        send_frame(8'hA5, 1'b1, 10, -1);
        wait_ticks(32);
        check("a5_data",       32'(bus.DATA), 32'h0000_00A5);
        check("a5_busy_ticks", 32'(busy_ticks), 32'd152);
        check("a5_valid_cnt",  32'(valid_cnt), 32'd1);
        check("a5_fe_cnt",     32'(fe_cnt), 32'd0);

        send_frame(8'h00, 1'b1, 10, -1);
        send_frame(8'hFF, 1'b1, 10, -1);
        wait_ticks(32);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
        check("b2b_data",      32'(bus.DATA), 32'h0000_00FF);

        send_frame(8'h3C, 1'b0, 10, -1);
        wait_ticks(48);
        check("break_busy",   32'(bus.BUSY), 32'd1);
        check("break_fe_cnt", 32'(fe_cnt), 32'd1);
        check("break_data",   32'(bus.DATA), 32'h0000_00FF);
        bus.RX = 1'b1;
        wait_ticks(16);
        check("break_exit_idle", 32'(bus.BUSY), 32'd0);
        send_frame(8'h5A, 1'b1, 10, -1);
        wait_ticks(32);
        check("after_break_data", 32'(bus.DATA), 32'h0000_005A);
        check("after_break_valid_cnt", 32'(valid_cnt), 32'd4);

        bus.RX = 1'b0;
        wait_ticks(2);
        check("glitch_busy", 32'(bus.BUSY), 32'd1);
        wait_ticks(2);
        bus.RX = 1'b1;
        wait_ticks(8);
        check("glitch_idle", 32'(bus.BUSY), 32'd0);
        wait_ticks(16);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd4);
        check("glitch_fe_cnt",    32'(fe_cnt), 32'd1);

        send_frame(8'h81, 1'b1, 6, -1);
        check("mid_frame_busy", 32'(bus.BUSY), 32'd1);
        RST    = 1'b1;
        bus.RX = 1'b1;
        exp_q.delete();
        model_data = 8'h00;
        #1;
        check("mid_rst_data",  32'(bus.DATA), 32'd0);
        check("mid_rst_busy",  32'(bus.BUSY), 32'd0);
        check("mid_rst_valid", 32'(bus.DATA_VALID), 32'd0);
        check("mid_rst_fe",    32'(bus.FRAME_ERR), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        wait_ticks(4);
        send_frame(8'h81, 1'b1, 10, -1);
        wait_ticks(32);
        check("post_rst_data",      32'(bus.DATA), 32'h0000_0081);
        check("post_rst_valid_cnt", 32'(valid_cnt), 32'd5);

        send_frame(8'hC3, 1'b1, 10, 4);
        wait_ticks(32);
        check("gap_data",      32'(bus.DATA), 32'h0000_00C3);
        check("gap_valid_cnt", 32'(valid_cnt), 32'd6);
        check("gap_fe_cnt",    32'(fe_cnt), 32'd1);
        check("events_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART transceiver; the receive-side counterpart of the transmit path. Consumes the 16× oversampling RX_TICK strobe from the baud generator, synchronises the asynchronous RX line, recovers 8N1 frames (LSB first) and presents each byte with a one-cycle valid strobe. Detects framing errors and start-bit glitches.

## Interface
- DATA_BITS, 8, data bits per frame
- OVERSAMPLE, 16, RX_TICK strobes per bit period
- CLK  input  1  system clock (50 MHz)
- RST  input  1  asynchronous, active-high reset
- RX_TICK  input  1  one-CLK strobe at OVERSAMPLE × baud
- RX  input  1  asynchronous serial line, idle high
- DATA  output  DATA_BITS  last good byte; holds until next good frame
- DATA_VALID  output  1  one-CLK pulse, DATA just updated
- FRAME_ERR  output  1  one-CLK pulse, stop bit sampled low
- BUSY  output  1  high in any state other than IDLE

## Operation
- RX passes through a 2-FF synchroniser; both flops reset to 1. All decisions use the synchronised value.
- The tick counter (width $clog2(OVERSAMPLE)) and the bit index (width $clog2(DATA_BITS+1)) advance only on CLK edges where RX_TICK=1.
- IDLE: on a tick with RX low -> START, tick counter cleared to 0.
- START: on tick count OVERSAMPLE/2-1 (7), if RX is still low -> DATA with counter and bit index cleared; if RX is high -> IDLE (glitch, no output).
- DATA: on each tick count OVERSAMPLE-1 (15), shift the sampled bit into the MSB of the shift register (LSB-first line order) and increment the bit index. After DATA_BITS samples -> STOP with counter cleared.
- STOP: on tick count 15, sample RX.
  - RX high: load DATA from the shift register, pulse DATA_VALID -> IDLE.
  - RX low: pulse FRAME_ERR; DATA is not updated -> BREAK.
- BREAK: stay until a tick samples RX high -> IDLE. This prevents a held-low line from retriggering the receiver.
- Counter wrap: the tick counter rolls 15->0 inside DATA and STOP. It is cleared on every state entry.
- RX_TICK idle: the FSM freezes and all outputs hold.

## Timing
- Reset values: DATA=0, DATA_VALID=0, FRAME_ERR=0, BUSY=0, state IDLE, synchroniser=1.
- RST asserted mid-frame aborts immediately: no DATA_VALID or FRAME_ERR is produced for the partial frame.
- DATA_VALID, FRAME_ERR and DATA are registered. They change on the CLK edge of the RX_TICK that takes the stop sample. The pulses last exactly one CLK cycle, and DATA_VALID and FRAME_ERR are never high together.
- Latency: 2 CLK of synchroniser delay plus sampling alignment. The start edge is detected on the first tick after synchronisation, within 1 tick period (±1/16 bit of jitter).
- Sampling points are 8, 24, 40, … ticks after start detection, i.e. the middle of each bit.
- BUSY rises on the same edge as IDLE->START and falls on the edge that returns the FSM to IDLE.
- Back-to-back frames: a start bit that begins right after the stop sample is accepted on the next tick. No idle gap is required beyond the remaining half stop bit.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK)
  - constants DATA_BITS, OVERSAMPLE, CLK_HZ=50_000_000 and BAUD=115_200
- One sub-module, rx_sync: a parameterised 2-FF synchroniser with reset value input. The transmit side reuses it for any asynchronous inputs.
- The FSM, counters, shift register and output registers stay in uart_rx.

## Test plan
The bench drives RX_TICK for 1 CLK every 28 CLK. One bit is 16 ticks = 448 CLK.
- Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> one DATA_VALID pulse, DATA=0xA5, FRAME_ERR never high, BUSY high for about 9.5 bits.
- Back-to-back 0x00 then 0xFF with no idle gap -> two DATA_VALID pulses, DATA=0x00 then 0xFF.
- 0x3C with stop bit driven low, then the line held low for 3 bit times -> FRAME_ERR pulses once and DATA keeps its prior value. No new frame starts until RX returns high; a following good 0x5A is then received correctly.
- RX low pulse of 4 ticks (glitch) -> FSM returns to IDLE, no pulses, BUSY low after tick 7.
- RST asserted during bit 4 of 0x81 -> all outputs reset immediately. After release, a clean 0x81 yields DATA=0x81.
- RX_TICK gated off mid-frame for 1000 CLK with RX stable, then resumed -> frame completes correctly, the same as with no gap.
